// File: rtl/exc_ctrl.sv
// exc_ctrl: exception sequencer driving EPC save, vector fetch and PC redirect.
// Define EXC_CAUSE_EN to add the 2-bit cause register and port.
module exc_ctrl #(
  parameter int unsigned MEM_LAT    = 2,
  parameter logic [31:0] VEC_OPCODE = 32'd253,
  parameter logic [31:0] VEC_OVF    = 32'd254,
  parameter logic [31:0] VEC_DIV0   = 32'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic        rfe,
  input  logic [31:0] pc_in,
  input  logic [7:0]  mem_data,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  output logic        epc_write,
  output logic [31:0] epc_data,
  output logic [31:0] handler_pc,
  output logic [2:0]  pc_sel,
  output logic        pc_write,
`ifdef EXC_CAUSE_EN
  output logic [1:0]  cause,
`endif
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    SAVE,
    READ,
    JUMP,
    RET
  } stateT;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  stateT       state;
  stateT       nextState;
  logic [3:0]  cnt;
  logic        cntZero;
  logic        excAny;
  logic [31:0] vecSel;

  assign excAny  = exc_opcode | exc_overflow | exc_div0;
  assign cntZero = (cnt == 4'd0);
  assign busy    = (state != IDLE);

  // Cause priority: opcode > overflow > div0.
  always_comb begin
    vecSel = VEC_DIV0;
    if (exc_opcode) begin
      vecSel = VEC_OPCODE;
    end else if (exc_overflow) begin
      vecSel = VEC_OVF;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (excAny) begin
          nextState = SAVE;
        end else if (rfe) begin
          nextState = RET;
        end
      end
      SAVE: nextState = READ;
      READ: begin
        if (cntZero) begin
          nextState = JUMP;
        end
      end
      JUMP: nextState = IDLE;
      RET:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Strobes are registered from the next-state decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_rd     <= 1'b0;
      epc_write  <= 1'b0;
      pc_write   <= 1'b0;
      pc_sel     <= 3'b000;
      mem_addr   <= '0;
      epc_data   <= '0;
      handler_pc <= '0;
      cnt        <= '0;
    end else begin
      mem_rd    <= (nextState == READ);
      epc_write <= (nextState == SAVE);
      pc_write  <= (nextState == JUMP) ||
                   (nextState == RET);
      unique case (1'b1)
        nextState == JUMP: pc_sel <= 3'b011;
        nextState == RET:  pc_sel <= 3'b100;
        default:           pc_sel <= 3'b000;
      endcase
      if (state == IDLE && excAny) begin
        mem_addr <= vecSel;
        epc_data <= pc_in - 32'd4;
      end
      if (state == SAVE) begin
        cnt <= LAT_M1;
      end else if (state == READ && !cntZero) begin
        cnt <= cnt - 4'd1;
      end
      if (state == READ && cntZero) begin
        handler_pc <= {24'd0, mem_data};
      end
    end
  end

`ifdef EXC_CAUSE_EN
  logic [1:0] causeSel;

  always_comb begin
    causeSel = 2'b11;
    if (exc_opcode) begin
      causeSel = 2'b01;
    end else if (exc_overflow) begin
      causeSel = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cause <= 2'b00;
    end else if (nextState == SAVE) begin
      cause <= causeSel;
    end else if (nextState == RET) begin
      cause <= 2'b00;
    end
  end
`endif

  strobeExcl: assert property (
    @(posedge clk) disable iff (!reset)
    $onehot0({mem_rd, epc_write, pc_write}));

  selIdle: assert property (
    @(posedge clk) disable iff (!reset)
    !pc_write |-> (pc_sel == 3'b000));

endmodule
